// File: rtl/debug_pkg.sv
// Shared types and constants for the debug UART arbiter.
package debug_pkg;

  // ARB_ABORT is only reachable when DEBUG_UART_ARB_TIMEOUT_EN is defined.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_HEADER  = 2'd1,
    ARB_PAYLOAD = 2'd2,
    ARB_ABORT   = 2'd3
  } debug_arb_state_t;

  localparam logic [7:0] DEBUG_ABORT_CHAR   = 8'hFF;
  localparam int         DEBUG_HDR_NIBBLE_W = 4;

  function automatic logic [7:0] debug_header(input logic [7:0] base,
                                              input logic [DEBUG_HDR_NIBBLE_W-1:0] id);
    return {base[7:4], id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin picker: first request after last_grant, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [3:0]   last_grant,
  output logic [N-1:0] grant,
  output logic [3:0]   grant_id
);

  always_comb begin
    int idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (!found && (j == idx) && req[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          grant_id = j[3:0];
        end
      end
    end
  end

endmodule

// File: rtl/debug_uart_arbiter.sv
// Packet-level round-robin sharing of one uart_transmit between debug byte streams.
// Optional mid-packet stall timeout with abort byte and flush: DEBUG_UART_ARB_TIMEOUT_EN.
module debug_uart_arbiter
  import debug_pkg::*;
#(
  parameter int          NUM_REQUESTERS = 4,
  parameter logic [7:0]  HEADER_BASE    = 8'hA0,
  parameter int          TIMEOUT_CYCLES = 65536
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQUESTERS-1:0]   req_valid,
  input  logic [NUM_REQUESTERS*8-1:0] req_data,
  input  logic [NUM_REQUESTERS-1:0]   req_last,
  output logic [NUM_REQUESTERS-1:0]   req_ready,
  input  logic                        tx_ready,
  output logic                        tx_enable,
  output logic [7:0]                  tx_char,
  output logic [3:0]                  grant_id,
  output logic                        busy
);

  localparam int         N          = NUM_REQUESTERS;
  localparam logic [3:0] LAST_INIT  = 4'(N - 1);

  if (N < 2 || N > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("debug_uart_arbiter: illegal parameter set");
  end

  debug_arb_state_t state, state_next;
  logic [3:0]       grant_id_next;
  logic [3:0]       last_grant, last_grant_next;
  logic [N-1:0]     eligible, win_onehot, sel_mask;
  logic [3:0]       win_id;
  logic             win_any;
  logic             sel_valid, sel_last, handshake;
  logic [7:0]       sel_data;

`ifdef DEBUG_UART_ARB_TIMEOUT_EN
  localparam int                STALL_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);
  logic [STALL_W-1:0] stall_cnt, stall_cnt_next;
  logic [N-1:0]       flush, flush_next;
  assign eligible = req_valid & ~flush;
`else
  assign eligible = req_valid;
`endif

  rr_arbiter #(.N(N)) u_rr (
    .req        (eligible),
    .last_grant (last_grant),
    .grant      (win_onehot),
    .grant_id   (win_id)
  );

  assign win_any   = |win_onehot;
  assign busy      = (state != ARB_IDLE);
  assign handshake = (state == ARB_PAYLOAD) && sel_valid && tx_ready;

  // Route the granted lane without a variable-width index into the N-wide vectors.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_mask  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_id == i[3:0]) begin
        sel_mask[i] = 1'b1;
        sel_valid   = req_valid[i];
        sel_last    = req_last[i];
        sel_data    = req_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      grant_id   <= '0;
      last_grant <= LAST_INIT;
`ifdef DEBUG_UART_ARB_TIMEOUT_EN
      stall_cnt  <= '0;
      flush      <= '0;
`endif
    end else begin
      state      <= state_next;
      grant_id   <= grant_id_next;
      last_grant <= last_grant_next;
`ifdef DEBUG_UART_ARB_TIMEOUT_EN
      stall_cnt  <= stall_cnt_next;
      flush      <= flush_next;
`endif
    end
  end

  always_comb begin
    state_next      = state;
    grant_id_next   = grant_id;
    last_grant_next = last_grant;
`ifdef DEBUG_UART_ARB_TIMEOUT_EN
    stall_cnt_next  = stall_cnt;
    // A flushing lane is released once its discarded packet ends.
    flush_next      = flush & ~(req_valid & req_last);
`endif
    case (state)
      ARB_IDLE: begin
        if (win_any) begin
          grant_id_next = win_id;
          state_next    = ARB_HEADER;
        end
      end
      ARB_HEADER: begin
`ifdef DEBUG_UART_ARB_TIMEOUT_EN
        stall_cnt_next = '0;
`endif
        if (tx_ready) state_next = ARB_PAYLOAD;
      end
      ARB_PAYLOAD: begin
        if (handshake && sel_last) begin
          last_grant_next = grant_id;
          state_next      = ARB_IDLE;
        end
`ifdef DEBUG_UART_ARB_TIMEOUT_EN
        if (handshake) begin
          stall_cnt_next = '0;
        end else if (!sel_valid) begin
          stall_cnt_next = stall_cnt + 1'b1;
          if (stall_cnt_next == STALL_LIMIT) state_next = ARB_ABORT;
        end
`endif
      end
`ifdef DEBUG_UART_ARB_TIMEOUT_EN
      ARB_ABORT: begin
        if (tx_ready) begin
          flush_next      = flush_next | sel_mask;
          last_grant_next = grant_id;
          state_next      = ARB_IDLE;
        end
      end
`endif
      default: state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    tx_enable = 1'b0;
    tx_char   = '0;
    req_ready = '0;
    case (state)
      ARB_HEADER: begin
        tx_enable = 1'b1;
        tx_char   = debug_header(HEADER_BASE, grant_id);
      end
      ARB_PAYLOAD: begin
        tx_enable = sel_valid;
        tx_char   = sel_data;
        req_ready = sel_mask & {N{sel_valid && tx_ready}};
      end
`ifdef DEBUG_UART_ARB_TIMEOUT_EN
      ARB_ABORT: begin
        tx_enable = 1'b1;
        tx_char   = DEBUG_ABORT_CHAR;
      end
`endif
      default: ;
    endcase
`ifdef DEBUG_UART_ARB_TIMEOUT_EN
    req_ready = req_ready | (flush & req_valid);
`endif
  end

endmodule

// File: tb/tb_debug_uart_arbiter.sv
// Directed bench for debug_uart_arbiter with a byte scoreboard on the UART side.
module tb_debug_uart_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*8-1:0] req_data;
  logic           tx_ready, tx_enable, busy;
  logic [7:0]     tx_char;
  logic [3:0]     grant_id;

  always #5 clk = ~clk;

  debug_uart_arbiter #(
    .NUM_REQUESTERS (N),
    .HEADER_BASE    (8'hA0),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_ready  (tx_ready),
    .tx_enable (tx_enable),
    .tx_char   (tx_char),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [8:0] src_q [N][$];
  logic [7:0] exp_q [$];
  int         acc_cyc [$];
  logic [N-1:0] hold = '0;
  logic [N-1:0] pop_mask;
  bit         toggle_mode = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_char = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        req_valid[i] = 1'b1;
        {req_last[i], req_data[i*8 +: 8]} = src_q[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  // Queue an n-byte packet on lane r and its header+payload on the scoreboard.
  task automatic load(input int r, input int n, input logic [7:0] seed);
    exp_q.push_back(8'hA0 | 8'(r));
    for (int k = 0; k < n; k++) begin
      src_q[r].push_back({(k == n - 1), seed + 8'(k)});
      exp_q.push_back(seed + 8'(k));
    end
    drive_lanes();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_exp(input string tag, input int target, input int budget);
    int k = 0;
    while (exp_q.size() > target && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(exp_q.size() <= target), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(exp_q.size() == 0 && busy === 1'b0), 32'd1);
  endtask

  // Observe on the falling edge; apply consumed bytes just after the rising edge.
  always begin
    @(negedge clk);
    cyc++;
    pop_mask = '0;
    if (reset) begin
      pop_mask = req_ready;
      if (tx_enable) begin
        if (prev_stall) chk("tx_char_hold", tx_char, prev_char);
        if (tx_ready) begin
          $display("tx %02h cycle %0d grant %0d", tx_char, cyc, grant_id);
          acc_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_char observed=%0h expected=none", tx_char);
          end else begin
            chk("tx_char", tx_char, exp_q.pop_front());
          end
        end
      end
      prev_stall = tx_enable && !tx_ready;
      prev_char  = tx_char;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (pop_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive_lanes();
    tx_ready = toggle_mode ? ~tx_ready : 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n0, d;
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    #2 reset  = 1'b0;
    tick(2);
    chk("rst_tx_enable", tx_enable, 0);
    chk("rst_tx_char",   tx_char,   0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_grant_id",  grant_id,  0);
    reset = 1'b1;
    tick(1);

    // All four lanes with 2-byte packets, tx_ready held high.
    acc_cyc.delete();
    t0 = cyc;
    load(0, 2, 8'h10);
    load(1, 2, 8'h20);
    load(2, 2, 8'h30);
    load(3, 2, 8'h40);
    wait_idle("t1_drain", 100);
    chk("t1_count", acc_cyc.size(), 12);
    if (acc_cyc.size() == 12) begin
      chk("t1_hdr_latency", acc_cyc[0] - t0, 2);
      for (int k = 1; k < 12; k++)
        chk("t1_gap", acc_cyc[k] - acc_cyc[k-1], (k % 3 == 0) ? 2 : 1);
    end
    chk("t1_grant_id", grant_id, 3);

    // Lane 2, 3 bytes, tx_ready toggling every cycle.
    toggle_mode = 1'b1;
    load(2, 3, 8'h50);
    wait_idle("t2_drain", 100);
    toggle_mode = 1'b0;
    chk("t2_src_empty", src_q[2].size(), 0);
    tick(2);

    // Lane 1 mid-packet (and stalling) while lane 0 requests: no preemption.
    load(1, 4, 8'h60);
    wait_exp("t3_started", 3, 50);
    hold[1] = 1'b1;
    drive_lanes();
    load(0, 2, 8'h70);
    tick(3);
    chk("t3_grant_held", grant_id, 1);
    chk("t3_busy",       busy,     1);
    chk("t3_no_filler",  tx_enable, 0);
    hold[1] = 1'b0;
    drive_lanes();
    wait_idle("t3_drain", 100);

    // Async reset in PAYLOAD, then the pointer restarts at lane 0.
    load(2, 4, 8'h80);
    wait_exp("t4_in_payload", 2, 50);
    reset = 1'b0;
    #1;
    chk("t4_busy",      busy,      0);
    chk("t4_tx_enable", tx_enable, 0);
    chk("t4_req_ready", req_ready, 0);
    chk("t4_grant_id",  grant_id,  0);
    src_q[2].delete();
    exp_q.delete();
    drive_lanes();
    tick(1);
    reset = 1'b1;
    load(0, 2, 8'h90);
    load(2, 2, 8'hA8);
    wait_idle("t4_drain", 100);

    // Single-byte packet from lane 3, then lanes 0 and 3 together with last_grant=3.
    n0 = acc_cyc.size();
    load(3, 1, 8'hB0);
    wait_idle("t5_single", 50);
    chk("t5_single_len", acc_cyc.size() - n0, 2);
    chk("t5_last_grant", grant_id, 3);
    load(0, 2, 8'hC0);
    load(3, 2, 8'hD0);
    wait_idle("t5_drain", 100);

`ifdef DEBUG_UART_ARB_TIMEOUT_EN
    // Lane 3 stalls after one byte: abort byte, then its tail is flushed.
    n0 = acc_cyc.size();
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'hFF);
    src_q[3].push_back({1'b0, 8'hE0});
    drive_lanes();
    wait_exp("t6_abort", 0, 100);
    if (acc_cyc.size() >= n0 + 3) begin
      d = acc_cyc[n0+2] - acc_cyc[n0+1];
      chk("t6_ff_delay", d, 16);
    end
    src_q[3].push_back({1'b0, 8'hE1});
    src_q[3].push_back({1'b1, 8'hE2});
    load(0, 2, 8'hF0);
    wait_idle("t6_drain", 100);
    chk("t6_flushed", src_q[3].size(), 0);
    load(3, 1, 8'hF8);
    wait_idle("t6_regrant", 50);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
